ysyx_24110015_inst_queue: RTL

Instruction queue between the fetch unit and the decode unit of the single-issue NPC core. It captures each fetched `{pc, inst}` pair, buffers up to `DEPTH` entries, and presents them in order to the decoder over a valid/ready handshake. This decouples fetch from decode stalls. A one-cycle `flush` input discards all buffered entries on a control-flow redirect.

---
 rtl/ysyx_24110015_inst_queue_if.sv | 30 +++
 rtl/ysyx_24110015_inst_queue.sv | 100 ++++++++++
 2 files changed

// File: rtl/ysyx_24110015_inst_queue_if.sv
// rtl/ysyx_24110015_inst_queue_if.sv - fetch/decode handshake bundle for the instruction queue
//
// Carries the push side (in_*), the pop side (out_*), the flush strobe
// and the occupancy count. The slave modport is the queue itself; the
// master modport is whatever drives fetch/decode around it.
interface ysyx_24110015_inst_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_inst;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_inst;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  flush, in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, count
    );

    modport master (
        output flush, in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, count
    );
endinterface

// File: rtl/ysyx_24110015_inst_queue.sv
// rtl/ysyx_24110015_inst_queue.sv - in-order {pc, inst} queue between fetch and decode
//
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - synchronous, active-low reset
//   q    - ysyx_24110015_inst_queue_if.slave:
//          flush                      discard all entries at the next posedge
//          in_valid/in_ready/in_pc/in_inst     push side (fetch)
//          out_valid/out_ready/out_pc/out_inst pop side (decode)
//          count                      number of stored entries, 0..DEPTH
//
// Optional feature: define YSYX_IQ_BYPASS_EN to let a pair arriving at an
// empty queue pass straight to the decoder in the same cycle.
module ysyx_24110015_inst_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_24110015_inst_queue_if.slave    q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   rptr;
    logic [AW-1:0]   wptr;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    logic live;
    logic empty;
    logic full;
    logic byp;
    logic push;
    logic pop;

    // Flush and reset both kill the handshakes in the same cycle they are asserted.
    assign live  = rst && !q.flush;
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

`ifdef YSYX_IQ_BYPASS_EN
    assign byp = live && empty && q.in_valid;
`else
    assign byp = 1'b0;
`endif

    // in_ready is a function of state only, so out_ready never reaches fetch.
    assign q.in_ready  = live && !full;
    assign q.out_valid = (live && !empty) || byp;

    // A bypassed pair that decode takes immediately is never written.
    assign push = q.in_valid && q.in_ready && !(byp && q.out_ready);
    assign pop  = q.out_valid && q.out_ready && !empty;

    always_comb begin
        q.out_pc   = '0;
        q.out_inst = '0;
        if (rst) begin
            if (!empty) begin
                q.out_pc   = pc_mem[rptr];
                q.out_inst = inst_mem[rptr];
            end else if (byp) begin
                q.out_pc   = q.in_pc;
                q.out_inst = q.in_inst;
            end
        end
    end

    assign q.count = rst ? cnt : '0;

    always_ff @(posedge clk) begin
        if (!rst || q.flush) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage holds no reset: stale slots are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]   <= q.in_pc;
            inst_mem[wptr] <= q.in_inst;
        end
    end
endmodule
